sdram_bus_responder: RTL and testbench

- Target-side model of the CPU's SDRAM bus: services both the instruction port (bus_i_sdram_*) and the data port (bus_d_sdram_*) from one shared word-addressed backing RAM.
- Latency is fixed and programmable, which gives the CPU/L1 cache benches and simple FPGA builds a cycle-deterministic memory.
- One access is in service at a time. The D port wins arbitration ties. Each port can hold one request pending.

---
 rtl/sdram_bus_responder.sv | 118 +++++++++++
 tb/tb_sdram_bus_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_bus_responder.sv
// sdram_bus_responder: fixed-latency, single-bank responder for the CPU I and D SDRAM ports sharing one word RAM
//   clk, reset                          bus clock, synchronous active-high reset
//   bus_i_sdram_addr/data/we/start      I-port request (word address, write data, write enable, strobe)
//   bus_i_sdram_q/done/ready            I-port read data, one-cycle completion pulse, may-issue-start
//   bus_d_sdram_*                       D-port equivalents; D wins ties against I
module sdram_bus_responder #(
   parameter int DEPTH_BITS = 10,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [26:0] bus_i_sdram_addr,
   input  logic [31:0] bus_i_sdram_data,
   input  logic        bus_i_sdram_we,
   input  logic        bus_i_sdram_start,
   output logic [31:0] bus_i_sdram_q,
   output logic        bus_i_sdram_done,
   output logic        bus_i_sdram_ready,
   input  logic [26:0] bus_d_sdram_addr,
   input  logic [31:0] bus_d_sdram_data,
   input  logic        bus_d_sdram_we,
   input  logic        bus_d_sdram_start,
   output logic [31:0] bus_d_sdram_q,
   output logic        bus_d_sdram_done,
   output logic        bus_d_sdram_ready
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam int AW = DEPTH_BITS;
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   logic [31:0] mem [2**DEPTH_BITS];
   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic sel_q, sel_d;
   logic [1:0] pend_q, pend_d, we_q, we_d, done_q, done_d;
   logic [1:0] start, acc, req, we_in;
   logic [1:0][AW-1:0] addr_q, addr_d, addr_in;
   logic [1:0][31:0] data_q, data_d, data_in, q_q, q_d;
   logic mem_we;
   logic unused_addr_hi;

   // index 0 is the I port, index 1 the D port; sel_q=1 means D is in service
   assign start   = {bus_d_sdram_start, bus_i_sdram_start};
   assign addr_in = {bus_d_sdram_addr[AW-1:0], bus_i_sdram_addr[AW-1:0]};
   assign data_in = {bus_d_sdram_data, bus_i_sdram_data};
   assign we_in   = {bus_d_sdram_we, bus_i_sdram_we};
   assign unused_addr_hi = ^{bus_d_sdram_addr[26:AW], bus_i_sdram_addr[26:AW]};
   // ready is simply "nothing pending"; a start while busy falls through untouched
   assign acc = start & ~pend_q;
   assign req = pend_q | acc;

   always_comb begin
      pend_d  = req;
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      done_d  = '0;
      q_d     = q_q;
      mem_we  = 1'b0;
      for (int p = 0; p < 2; p++) begin
         addr_d[p] = acc[p] ? addr_in[p] : addr_q[p];
         data_d[p] = acc[p] ? data_in[p] : data_q[p];
         we_d[p]   = acc[p] ? we_in[p] : we_q[p];
      end
      if (state_q == IDLE) begin
         if (|req) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
            sel_d   = req[1];
         end
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end else begin
         // completion: commit the write or capture read data, then hand the bank
         // straight to the other port if it has a request, with no idle gap
         done_d[sel_q] = 1'b1;
         pend_d[sel_q] = 1'b0;
         mem_we        = we_q[sel_q];
         q_d[sel_q]    = we_q[sel_q] ? 32'd0 : mem[addr_q[sel_q]];
         state_d       = req[~sel_q] ? BUSY : IDLE;
         cnt_d         = req[~sel_q] ? CNT_LOAD : 8'd0;
         sel_d         = ~sel_q;
      end
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
      we_q   <= we_d;
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         sel_q   <= 1'b0;
         pend_q  <= '0;
         done_q  <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         q_q     <= q_d;
      end
   end

   // RAM survives reset; only a completed write may change it
   always_ff @(posedge clk) begin
      if (mem_we && !reset) mem[addr_q[sel_q]] <= data_q[sel_q];
   end

   assign bus_i_sdram_q     = q_q[0];
   assign bus_i_sdram_done  = done_q[0];
   assign bus_i_sdram_ready = ~pend_q[0];
   assign bus_d_sdram_q     = q_q[1];
   assign bus_d_sdram_done  = done_q[1];
   assign bus_d_sdram_ready = ~pend_q[1];
endmodule

// File: tb/tb_sdram_bus_responder.sv
// tb_sdram_bus_responder: directed and randomized checks of sdram_bus_responder against a transaction-level model
module tb_sdram_bus_responder;
   localparam int L = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [26:0] i_addr = '0, d_addr = '0, n_i_addr = '0, n_d_addr = '0;
   logic [31:0] i_data = '0, d_data = '0, n_i_data = '0, n_d_data = '0;
   logic i_we = 1'b0, d_we = 1'b0, i_start = 1'b0, d_start = 1'b0;
   logic n_i_we = 1'b0, n_d_we = 1'b0, n_i_start = 1'b0, n_d_start = 1'b0;
   logic [31:0] i_q, d_q, n_i_q, n_d_q;
   logic i_done, d_done, i_ready, d_ready, n_i_done, n_d_done, n_i_ready, n_d_ready;

   int total = 0;
   int bad = 0;
   logic [31:0] mem_m [1024];
   logic [31:0] eq_d = '0, eq_i = '0;

   always #5 clk = ~clk;

   sdram_bus_responder #(.DEPTH_BITS(10), .LATENCY(L)) dut (
      .clk(clk), .reset(reset),
      .bus_i_sdram_addr(i_addr), .bus_i_sdram_data(i_data), .bus_i_sdram_we(i_we),
      .bus_i_sdram_start(i_start), .bus_i_sdram_q(i_q), .bus_i_sdram_done(i_done),
      .bus_i_sdram_ready(i_ready),
      .bus_d_sdram_addr(d_addr), .bus_d_sdram_data(d_data), .bus_d_sdram_we(d_we),
      .bus_d_sdram_start(d_start), .bus_d_sdram_q(d_q), .bus_d_sdram_done(d_done),
      .bus_d_sdram_ready(d_ready)
   );

   sdram_bus_responder #(.DEPTH_BITS(10), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .bus_i_sdram_addr(n_i_addr), .bus_i_sdram_data(n_i_data), .bus_i_sdram_we(n_i_we),
      .bus_i_sdram_start(n_i_start), .bus_i_sdram_q(n_i_q), .bus_i_sdram_done(n_i_done),
      .bus_i_sdram_ready(n_i_ready),
      .bus_d_sdram_addr(n_d_addr), .bus_d_sdram_data(n_d_data), .bus_d_sdram_we(n_d_we),
      .bus_d_sdram_start(n_d_start), .bus_d_sdram_q(n_d_q), .bus_d_sdram_done(n_d_done),
      .bus_d_sdram_ready(n_d_ready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one request on D, I or both on the same edge and watch the bus until well past completion.
   // Model: D is served first, each service takes L cycles back to back.
   task automatic run_txn(input bit dd, input bit di,
                          input logic [26:0] da, input logic [31:0] dw, input bit dwe,
                          input logic [26:0] ia, input logic [31:0] iw, input bit iwe,
                          input bit nag, input string tag);
      int edt, eit, dt, it, dc, ic, rerr;
      if (dd) begin
         if (dwe) begin mem_m[da[9:0]] = dw; eq_d = '0; end
         else eq_d = mem_m[da[9:0]];
      end
      if (di) begin
         if (iwe) begin mem_m[ia[9:0]] = iw; eq_i = '0; end
         else eq_i = mem_m[ia[9:0]];
      end
      edt = L;
      eit = dd ? 2 * L : L;
      d_start = dd; d_addr = da; d_data = dw; d_we = dwe;
      i_start = di; i_addr = ia; i_data = iw; i_we = iwe;
      step();
      d_start = 1'b0;
      i_start = 1'b0;
      dt = 0; it = 0; dc = 0; ic = 0; rerr = 0;
      for (int k = 1; k <= 2 * L + 4; k++) begin
         if (nag && k == 2) begin
            d_start = 1'b1; d_addr = 27'h3ff; d_data = 32'hbad0bad0; d_we = 1'b1;
         end
         if (nag && k == 3) d_start = 1'b0;
         step();
         if (d_done === 1'b1) begin dc++; dt = k; end
         if (i_done === 1'b1) begin ic++; it = k; end
         if (d_ready !== (!dd || k >= edt)) rerr++;
         if (i_ready !== (!di || k >= eit)) rerr++;
         if (d_done === 1'b1 && i_done === 1'b1) rerr++;
      end
      chk({tag, " d_done_count"}, 32'(dc), 32'(dd));
      chk({tag, " i_done_count"}, 32'(ic), 32'(di));
      chk({tag, " d_done_cycle"}, 32'(dt), dd ? 32'(edt) : 32'd0);
      chk({tag, " i_done_cycle"}, 32'(it), di ? 32'(eit) : 32'd0);
      chk({tag, " d_q"}, d_q, eq_d);
      chk({tag, " i_q"}, i_q, eq_i);
      chk({tag, " ready_overlap_errs"}, 32'(rerr), 32'd0);
   endtask

   initial begin
      int dc;
      int mode;
      // reset, with a start presented during reset that must be dropped
      step();
      d_start = 1'b1; d_addr = 27'h7; d_data = 32'h77; d_we = 1'b1;
      step();
      d_start = 1'b0;
      chk("rst d_ready", 32'(d_ready), 32'd1);
      chk("rst i_ready", 32'(i_ready), 32'd1);
      chk("rst d_done", 32'(d_done), 32'd0);
      chk("rst i_done", 32'(i_done), 32'd0);
      chk("rst d_q", d_q, 32'd0);
      chk("rst i_q", i_q, 32'd0);
      reset = 1'b0;
      dc = 0;
      for (int k = 0; k < 2 * L + 2; k++) begin
         step();
         if (d_done === 1'b1 || i_done === 1'b1) dc++;
      end
      chk("start_in_reset dones", 32'(dc), 32'd0);

      run_txn(1, 0, 27'h005, 32'hDEADBEEF, 1, 27'h0, 32'h0, 0, 0, "t1 d_write");
      run_txn(0, 1, 27'h0, 32'h0, 0, 27'h005, 32'h0, 0, 0, "t2 i_read");
      run_txn(1, 1, 27'h010, 32'h12345678, 1, 27'h010, 32'h0, 0, 0, "t3 d_wr_i_rd");
      run_txn(1, 0, 27'h400, 32'hA5A5A5A5, 1, 27'h0, 32'h0, 0, 1, "t4 alias_wr_nag");
      run_txn(0, 1, 27'h0, 32'h0, 0, 27'h000, 32'h0, 0, 0, "t4 alias_rd");

      // reset in the middle of a write: discarded, RAM unchanged
      run_txn(1, 0, 27'h020, 32'h22222222, 1, 27'h0, 32'h0, 0, 0, "t5 pre_write");
      d_start = 1'b1; d_addr = 27'h020; d_data = 32'h11111111; d_we = 1'b1;
      step();
      d_start = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      eq_d = '0;
      eq_i = '0;
      dc = 0;
      for (int k = 0; k < 2 * L + 2; k++) begin
         step();
         if (d_done === 1'b1 || i_done === 1'b1) dc++;
      end
      chk("t5 dones_after_reset", 32'(dc), 32'd0);
      chk("t5 d_ready", 32'(d_ready), 32'd1);
      chk("t5 i_ready", 32'(i_ready), 32'd1);
      chk("t5 d_q", d_q, 32'd0);
      run_txn(0, 1, 27'h0, 32'h0, 0, 27'h020, 32'h0, 0, 0, "t5 read_old");

      // randomized traffic over a small aliased address set
      for (int a = 0; a < 8; a++)
         run_txn(1, 0, 27'(a), $urandom, 1, 27'h0, 32'h0, 0, 0, "init");
      for (int n = 0; n < 30; n++) begin
         mode = $urandom_range(0, 2);
         run_txn(mode != 1, mode != 0,
                 {17'($urandom), 10'($urandom_range(0, 7))}, $urandom, 1'($urandom),
                 {17'($urandom), 10'($urandom_range(0, 7))}, $urandom, 1'($urandom),
                 0, "rand");
      end

      // LATENCY=1 instance: seed two words, then back-to-back reads with start held high
      n_d_start = 1'b1; n_d_addr = 27'h0; n_d_data = 32'hCAFE0000; n_d_we = 1'b1;
      step();
      n_d_start = 1'b0;
      step();
      chk("t6 wr0 done", 32'(n_d_done), 32'd1);
      n_d_start = 1'b1; n_d_addr = 27'h1; n_d_data = 32'hCAFE0001; n_d_we = 1'b1;
      step();
      n_d_start = 1'b0;
      step();
      chk("t6 wr1 done", 32'(n_d_done), 32'd1);
      chk("t6 wr1 q", n_d_q, 32'd0);
      n_d_start = 1'b1; n_d_addr = 27'h0; n_d_we = 1'b0;
      step();
      chk("t6 rd0 ready_low", 32'(n_d_ready), 32'd0);
      chk("t6 rd0 not_done", 32'(n_d_done), 32'd0);
      step();
      chk("t6 rd0 done", 32'(n_d_done), 32'd1);
      chk("t6 rd0 q", n_d_q, 32'hCAFE0000);
      chk("t6 rd0 ready", 32'(n_d_ready), 32'd1);
      n_d_addr = 27'h1;
      step();
      chk("t6 rd1 accepted", 32'(n_d_ready), 32'd0);
      chk("t6 rd1 not_done", 32'(n_d_done), 32'd0);
      n_d_start = 1'b0;
      step();
      chk("t6 rd1 done", 32'(n_d_done), 32'd1);
      chk("t6 rd1 q", n_d_q, 32'hCAFE0001);
      step();
      chk("t6 done_one_cycle", 32'(n_d_done), 32'd0);
      chk("t6 i_idle", 32'(n_i_done), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
